// File: rtl/apb_sync_pkg.sv
// Shared definitions for the destination-domain bus synchronizer.
package apb_sync_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      VALID = 2'b01,
      ACK   = 2'b10
   } sync_state_t;

   localparam int NUM_STAGES_MIN = 2;
endpackage

// File: rtl/sync_chain.sv
// Plain flop chain used to bring a single-bit level into Destination_CLK.
module sync_chain
   import apb_sync_pkg::*;
#(
   parameter int NUM_STAGES = 2
) (
   input  logic Destination_CLK,
   input  logic RST,
   input  logic d,
   output logic q
);

   logic [NUM_STAGES-1:0] ff;

   if (NUM_STAGES < NUM_STAGES_MIN) begin : g_stage_check
      $error("sync_chain: NUM_STAGES below minimum");
   end

   always_ff @(posedge Destination_CLK or negedge RST) begin
      if (!RST) ff <= '0;
      else      ff <= {ff[NUM_STAGES-2:0], d};
   end

   assign q = ff[NUM_STAGES-1];

endmodule

// File: rtl/apb_data_sync.sv
// Destination-side bus synchronizer: captures the source bus on a synced
// enable edge, hands it downstream with valid/ready, and returns a 4-phase ack.
//
// state | meaning
// IDLE  | waiting for a rising edge on the synchronized enable
// VALID | word held in Sync_bus, waiting for downstream Out_ready
// ACK   | Ack high, waiting for the source to drop its enable
module apb_data_sync
   import apb_sync_pkg::*;
#(
   parameter int BUS_WIDTH  = 8,
   parameter int NUM_STAGES = 2,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                 Destination_CLK,
   input  logic                 RST,
   input  logic [BUS_WIDTH-1:0] Unsync_bus,
   input  logic                 Bus_enable,
   output logic [BUS_WIDTH-1:0] Sync_bus,
   output logic                 Enable_pulse,
   output logic                 Out_valid,
   input  logic                 Out_ready,
   output logic                 Ack,
   output logic                 Proto_err,
   output logic [CNT_WIDTH-1:0] Xfer_cnt
);

   sync_state_t          state_q, state_d;
   logic                 en_sync, en_prev, rise, fall;
   logic [BUS_WIDTH-1:0] bus_d;
   logic [CNT_WIDTH-1:0] cnt_d;
   logic                 pulse_d, valid_d, ack_d, err_d;

   sync_chain #(.NUM_STAGES(NUM_STAGES)) u_en_sync (
      .Destination_CLK (Destination_CLK),
      .RST             (RST),
      .d               (Bus_enable),
      .q               (en_sync)
   );

   assign rise = en_sync & ~en_prev;
   assign fall = ~en_sync & en_prev;

   always_comb begin
      state_d = state_q;
      bus_d   = Sync_bus;
      cnt_d   = Xfer_cnt;
      pulse_d = 1'b0;
      valid_d = Out_valid;
      ack_d   = Ack;
      // The source withdrawing its request before the ack is a violation,
      // but the captured word is still delivered.
      err_d   = Proto_err | ((state_q == VALID) & fall);
      case (state_q)
         IDLE: begin
            if (rise) begin
               bus_d   = Unsync_bus;
               valid_d = 1'b1;
               pulse_d = 1'b1;
               state_d = VALID;
            end
         end
         VALID: begin
            if (Out_valid && Out_ready) begin
               valid_d = 1'b0;
               ack_d   = 1'b1;
               cnt_d   = Xfer_cnt + CNT_WIDTH'(1);
               state_d = ACK;
            end
         end
         ACK: begin
            if (!en_sync) begin
               ack_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            ack_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Destination_CLK or negedge RST) begin
      if (!RST) begin
         state_q      <= IDLE;
         en_prev      <= 1'b0;
         Sync_bus     <= '0;
         Enable_pulse <= 1'b0;
         Out_valid    <= 1'b0;
         Ack          <= 1'b0;
         Proto_err    <= 1'b0;
         Xfer_cnt     <= '0;
      end else begin
         state_q      <= state_d;
         en_prev      <= en_sync;
         Sync_bus     <= bus_d;
         Enable_pulse <= pulse_d;
         Out_valid    <= valid_d;
         Ack          <= ack_d;
         Proto_err    <= err_d;
         Xfer_cnt     <= cnt_d;
      end
   end

endmodule

// File: doc/apb_data_sync.md
Name: apb_data_sync

Overview:
- Destination-domain multi-bit bus synchronizer with a 4-phase req/ack handshake back to the source domain.
- Consumes a level enable from the source domain, synchronizes it, and detects its rising edge as a one-cycle pulse.
- On that pulse it captures the stable source bus into a holding register and presents it downstream with valid/ready.
- Ack is returned only after the downstream consumer accepts the word, giving end-to-end backpressure across the clock boundary.

Parameters:
- BUS_WIDTH, 8, width of the data bus crossing domains.
- NUM_STAGES, 2, synchronizer flops on Bus_enable; legal range >=2.
- CNT_WIDTH, 8, width of the transfer counter.

Ports:
- Destination_CLK  input  1  destination clock.
- RST  input  1  reset, asynchronous, active-low.
- Unsync_bus  input  BUS_WIDTH  source-domain data; held stable by the source from Bus_enable rise until Ack seen high.
- Bus_enable  input  1  source-domain request level; unsynchronized.
- Sync_bus  output  BUS_WIDTH  captured data; valid while Out_valid=1.
- Enable_pulse  output  1  one-cycle strobe on the capture edge.
- Out_valid  output  1  holding register full.
- Out_ready  input  1  downstream accept.
- Ack  output  1  level returned to the source domain; the source synchronizes it.
- Proto_err  output  1  sticky protocol-violation flag.
- Xfer_cnt  output  CNT_WIDTH  count of completed transfers.

Behaviour:
- Reset (RST=0, asynchronous):
  - Sync chain, en_prev, Sync_bus, Enable_pulse, Out_valid, Ack, Proto_err and Xfer_cnt all clear to 0.
  - State goes to IDLE.
  - Reset mid-transfer drops Ack and Out_valid immediately, and any held data is discarded.
- Sync chain: en_sync is the last of NUM_STAGES flops on Bus_enable. en_prev registers en_sync. rise = en_sync & ~en_prev.
- Latency: Bus_enable is sampled high at edge 1, en_sync goes high at edge NUM_STAGES, and at edge NUM_STAGES+1 Enable_pulse=1, Sync_bus<=Unsync_bus and Out_valid=1.
- Enable_pulse is registered and high for exactly one cycle per rise of en_sync.
- FSM IDLE:
  - On rise: capture, Out_valid<=1, go to VALID.
  - Ack stays 0.
- FSM VALID:
  - Sync_bus is held constant.
  - On Out_valid & Out_ready: Out_valid<=0, Ack<=1, Xfer_cnt<=Xfer_cnt+1 (wraps modulo 2^CNT_WIDTH), go to ACK.
  - If en_sync falls while in VALID: Proto_err<=1, and the state is unchanged; the data is still delivered.
- FSM ACK:
  - Wait for en_sync==0, then Ack<=0 and go to IDLE.
  - A new rise can only occur after returning to IDLE.
- Out_ready while Out_valid=0 is ignored.
- A one-cycle valid/ready overlap is a single transfer; no double count.
- Proto_err clears only on reset.
- Bus_enable glitches shorter than one Destination_CLK may be missed; this is legal.
- Back-to-back transfers: the minimum period per word is about 2*(NUM_STAGES+1) destination cycles plus the source-side ack sync.

Decomposition:
- Shared package apb_sync_pkg holds:
  - the state encoding (IDLE=2'b00, VALID=2'b01, ACK=2'b10);
  - NUM_STAGES_MIN=2.
- Sub-module sync_chain (parameter NUM_STAGES, Destination_CLK, RST, 1-bit in/out) contains the flop chain only.
- Edge detect, FSM, holding register and counter live in the top.

Test Plan:
- Reset: RST=0 with Bus_enable=1 -> all outputs 0. After release with NUM_STAGES=2, Enable_pulse and Out_valid rise at the 3rd edge and Sync_bus=Unsync_bus=8'hA5.
- Backpressure: Out_ready=0 for 10 cycles after capture -> Out_valid stays 1, Sync_bus stays 8'hA5 and Ack stays 0. Out_ready=1 -> Out_valid=0 and Ack=1 next edge, Xfer_cnt=1.
- Ack return: drop Bus_enable in ACK -> Ack=0 NUM_STAGES+1 edges later and the state returns to IDLE. A second word 8'h3C -> Xfer_cnt=2.
- Protocol violation: drop Bus_enable while Out_valid=1 -> Proto_err=1 (sticky), and the word is still delivered on Out_ready.
- Reset mid-transfer: RST=0 in VALID -> Out_valid=0 and Ack=0 immediately. A fresh handshake then completes normally.
- Counter wrap: CNT_WIDTH=2, 5 transfers -> Xfer_cnt=1.
